dpram_tdp_be: RTL and testbench
===============================

Name: dpram_tdp_be

Overview:
Parametrised true dual-port synchronous RAM. It is the next generation of the team's simple dpram. Additions:
- per-port enables and byte-write enables
- selectable same-port read-during-write mode
- optional output pipeline register with read-valid tracking
- deterministic write-write collision resolution with a collision flag

It serves as the shared buffer between two independent masters in the same clock domain.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
ADDRESS_WIDTH, 4, address bits per port
DEPTH, 16, number of words; must satisfy DEPTH <= 2**ADDRESS_WIDTH
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data)
OUT_REG, 0, 0 = 1-cycle read latency; 1 = 2-cycle latency (extra output register)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
en_a  input  1  port A access enable
we_a  input  1  port A write enable; ignored when en_a=0
be_a  input  DATA_WIDTH/8  port A byte enables; bit k covers bits [8k+7:8k]
addr_a  input  ADDRESS_WIDTH  port A address
data_in_a  input  DATA_WIDTH  port A write data
data_out_a  output  DATA_WIDTH  port A read data
rd_valid_a  output  1  data_out_a holds the result of an accepted access
en_b, we_b, be_b, addr_b, data_in_b, data_out_b, rd_valid_b: port B equivalents, same widths
collision  output  1  one-cycle pulse: a same-address write-write collision occurred
addr_err  output  1  one-cycle pulse: an enabled access used addr >= DEPTH

Behaviour:
Reset (rst_n=0, asynchronous):
- data_out_a/b=0, rd_valid_a/b=0, collision=0, addr_err=0, pipeline registers cleared.
- Memory array is NOT cleared; its contents are preserved across reset.
- Reset asserted mid-access aborts that access: no write is committed on a clock edge while rst_n=0, and in-flight valids are dropped.

Access:
- Accepted on a rising edge when en_x=1.
- Write: only bytes with be_x[k]=1 are updated; other bytes are unchanged.
- Every accepted access, read or write, also produces read data for addr_x.

Latency:
- OUT_REG=0: data_out_x and rd_valid_x update on the edge that accepts the access, so data is visible from cycle N+1.
- OUT_REG=1: one extra register stage; data is visible from cycle N+2, and rd_valid_x is delayed to match.
- en_x=0: data_out_x holds its last value; rd_valid_x=0 for the corresponding output cycle.
- Back-to-back accesses are allowed every cycle on both ports; there are no stalls.

Same-port read-during-write:
- RDW_MODE=0: data_out returns the word before the write.
- RDW_MODE=1: data_out returns the word after the byte-merged write.

Cross-port, A writes address X while B reads X in the same cycle:
- B always returns the old word, regardless of RDW_MODE; the symmetric case for A reading is the same.
- The new value is visible to the other port from the next access onward.

Write-write collision (both ports write the same in-range address in the same cycle):
- Bytes enabled on A take A's data.
- Bytes enabled only on B take B's data.
- collision pulses high for one cycle, aligned with the rd_valid timing of that access.
- Same address with only one port writing is not a collision.

Out-of-range address (addr >= DEPTH):
- The write is dropped and read data is 0.
- rd_valid still asserts for the access; addr_err pulses aligned with rd_valid.
- If both ports are out of range, addr_err is a single pulse.

Address wrap: none; there is no auto-increment, and addresses are used as given.

Test Plan:
- Fill then read: A writes i -> 16'h1000+i, be=2'b11, for i=0..15; then B reads 0..15 -> data_out_b=16'h1000+i one cycle after each read (OUT_REG=0), rd_valid_b=1, collision=0.
- Byte enables: A writes 16'hAAAA at addr 3, then 16'h5555 with be=2'b01 at addr 3 -> a subsequent read of addr 3 returns 16'hAA55.
- Read-during-write: addr 5 holds 16'h1111; A writes 16'h2222 at addr 5 while B reads addr 5 in the same cycle. Required: RDW_MODE=0 gives data_out_a=16'h1111; RDW_MODE=1 gives data_out_a=16'h2222. In both modes data_out_b=16'h1111, and a B read on the next cycle returns 16'h2222.
- Collision: same cycle, A writes 16'hABCD with be=2'b10 and B writes 16'h1234 with be=2'b11, both to addr 7 -> memory holds 16'hAB34, and collision pulses for exactly one cycle.
- Latency and reset: with OUT_REG=1, a read of addr 2 holding 16'h00F0 gives data_out=16'h00F0 and rd_valid two cycles after acceptance. Pulse rst_n low asynchronously between edges -> all outputs go to 0 immediately; re-read of addr 2 still returns 16'h00F0.
- Range check: with DEPTH=12 and ADDRESS_WIDTH=4, A writes addr 13 -> addr_err pulses once; a read of addr 13 returns 0; addresses 0..11 are unchanged.

Source files
------------

// File: rtl/dpram_tdp_be.sv
`default_nettype none
// ============================================================================
// Module      : dpram_tdp_be
// Description : True dual-port synchronous RAM with byte-write enables,
//               selectable same-port read-during-write behaviour, optional
//               output pipeline register, and write-write collision handling.
//               Port A wins every byte it enables when both ports write the
//               same word.
// Ports       : clk, rst_n (async, active-low)
//               en_x / we_x / be_x / addr_x / data_in_x : port x access request
//               data_out_x / rd_valid_x                 : port x read result
//               collision : same-address write-write pulse
//               addr_err  : out-of-range access pulse
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_tdp_be #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int DEPTH         = 16,
    parameter int RDW_MODE      = 0,
    parameter int OUT_REG       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_a,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDRESS_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0]   data_in_a,
    output logic [DATA_WIDTH-1:0]   data_out_a,
    output logic                    rd_valid_a,
    input  logic                    en_b,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDRESS_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]   data_in_b,
    output logic [DATA_WIDTH-1:0]   data_out_b,
    output logic                    rd_valid_b,
    output logic                    collision,
    output logic                    addr_err
);

    localparam int                     c_nbytes = DATA_WIDTH / 8;
    // Index width actually needed by the array; the upper address bits only
    // matter for the range check.
    localparam int                     c_iw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] c_depth  = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_inr_a, w_inr_b;
    logic                  w_wr_a, w_wr_b;
    logic [c_iw-1:0]       w_idx_a, w_idx_b;
    logic [DATA_WIDTH-1:0] w_old_a, w_old_b;
    logic [DATA_WIDTH-1:0] w_new_a, w_new_b;
    logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;

    logic                  r_vld1_a, r_vld1_b;
    logic [DATA_WIDTH-1:0] r_dout1_a, r_dout1_b;
    logic                  r_coll1, r_aerr1;

    assign w_inr_a = ({1'b0, addr_a} < c_depth);
    assign w_inr_b = ({1'b0, addr_b} < c_depth);
    assign w_wr_a  = en_a & we_a & w_inr_a;
    assign w_wr_b  = en_b & we_b & w_inr_b;
    assign w_idx_a = addr_a[c_iw-1:0];
    assign w_idx_b = addr_b[c_iw-1:0];

    // Array reads always see the pre-edge contents, which gives the
    // cross-port "old data" behaviour for free.
    assign w_old_a = w_inr_a ? r_mem[w_idx_a] : '0;
    assign w_old_b = w_inr_b ? r_mem[w_idx_b] : '0;

    // Own-port byte merge used for write-first read data.
    always_comb begin
        w_new_a = w_old_a;
        w_new_b = w_old_b;
        for (int k = 0; k < c_nbytes; k++) begin
            if (w_wr_a && be_a[k]) w_new_a[k*8 +: 8] = data_in_a[k*8 +: 8];
            if (w_wr_b && be_b[k]) w_new_b[k*8 +: 8] = data_in_b[k*8 +: 8];
        end
    end

    assign w_rd_a = (RDW_MODE != 0) ? w_new_a : w_old_a;
    assign w_rd_b = (RDW_MODE != 0) ? w_new_b : w_old_b;

    // Memory array has no reset so its contents survive rst_n, but no write
    // commits while reset is held. B is written first so that A's later
    // assignment to the same byte takes priority on collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < c_nbytes; k++) begin
                if (w_wr_b && be_b[k]) r_mem[w_idx_b][k*8 +: 8] <= data_in_b[k*8 +: 8];
                if (w_wr_a && be_a[k]) r_mem[w_idx_a][k*8 +: 8] <= data_in_a[k*8 +: 8];
            end
        end
    end

    // First output stage: data holds when the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1_a  <= 1'b0;
            r_vld1_b  <= 1'b0;
            r_dout1_a <= '0;
            r_dout1_b <= '0;
            r_coll1   <= 1'b0;
            r_aerr1   <= 1'b0;
        end else begin
            r_vld1_a <= en_a;
            r_vld1_b <= en_b;
            if (en_a) r_dout1_a <= w_rd_a;
            if (en_b) r_dout1_b <= w_rd_b;
            r_coll1  <= w_wr_a & w_wr_b & (addr_a == addr_b);
            r_aerr1  <= (en_a & ~w_inr_a) | (en_b & ~w_inr_b);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_vld2_a, r_vld2_b;
            logic [DATA_WIDTH-1:0] r_dout2_a, r_dout2_b;
            logic                  r_coll2, r_aerr2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld2_a  <= 1'b0;
                    r_vld2_b  <= 1'b0;
                    r_dout2_a <= '0;
                    r_dout2_b <= '0;
                    r_coll2   <= 1'b0;
                    r_aerr2   <= 1'b0;
                end else begin
                    r_vld2_a <= r_vld1_a;
                    r_vld2_b <= r_vld1_b;
                    if (r_vld1_a) r_dout2_a <= r_dout1_a;
                    if (r_vld1_b) r_dout2_b <= r_dout1_b;
                    r_coll2  <= r_coll1;
                    r_aerr2  <= r_aerr1;
                end
            end

            assign data_out_a = r_dout2_a;
            assign data_out_b = r_dout2_b;
            assign rd_valid_a = r_vld2_a;
            assign rd_valid_b = r_vld2_b;
            assign collision  = r_coll2;
            assign addr_err   = r_aerr2;
        end else begin : g_no_out_reg
            assign data_out_a = r_dout1_a;
            assign data_out_b = r_dout1_b;
            assign rd_valid_a = r_vld1_a;
            assign rd_valid_b = r_vld1_b;
            assign collision  = r_coll1;
            assign addr_err   = r_aerr1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dpram_tdp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_tdp_be
// Description : Directed bench for dpram_tdp_be. Four instances share one
//               stimulus: u0 default, u1 write-first, u2 output register,
//               u3 DEPTH=12.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_tdp_be;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 0, we_a = 0, en_b = 0, we_b = 0;
    logic [1:0]  be_a = 0, be_b = 0;
    logic [3:0]  addr_a = 0, addr_b = 0;
    logic [15:0] din_a = 0, din_b = 0;

    logic [15:0] dout_a [4];
    logic [15:0] dout_b [4];
    logic        vld_a [4];
    logic        vld_b [4];
    logic        coll [4];
    logic        aerr [4];

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_mem [16];

    always #5 clk = ~clk;

    dpram_tdp_be #(.RDW_MODE(0), .OUT_REG(0), .DEPTH(16)) u0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
        .data_out_a(dout_a[0]), .rd_valid_a(vld_a[0]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
        .data_out_b(dout_b[0]), .rd_valid_b(vld_b[0]),
        .collision(coll[0]), .addr_err(aerr[0]));

    dpram_tdp_be #(.RDW_MODE(1), .OUT_REG(0), .DEPTH(16)) u1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
        .data_out_a(dout_a[1]), .rd_valid_a(vld_a[1]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
        .data_out_b(dout_b[1]), .rd_valid_b(vld_b[1]),
        .collision(coll[1]), .addr_err(aerr[1]));

    dpram_tdp_be #(.RDW_MODE(0), .OUT_REG(1), .DEPTH(16)) u2 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
        .data_out_a(dout_a[2]), .rd_valid_a(vld_a[2]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
        .data_out_b(dout_b[2]), .rd_valid_b(vld_b[2]),
        .collision(coll[2]), .addr_err(aerr[2]));

    dpram_tdp_be #(.RDW_MODE(0), .OUT_REG(0), .DEPTH(12)) u3 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(din_a),
        .data_out_a(dout_a[3]), .rd_valid_a(vld_a[3]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(din_b),
        .data_out_b(dout_b[3]), .rd_valid_b(vld_b[3]),
        .collision(coll[3]), .addr_err(aerr[3]));

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic we, input logic [1:0] be,
                         input logic [3:0] ad, input logic [15:0] d);
        en_a = en; we_a = we; be_a = be; addr_a = ad; din_a = d;
    endtask

    task automatic set_b(input logic en, input logic we, input logic [1:0] be,
                         input logic [3:0] ad, input logic [15:0] d);
        en_b = en; we_b = we; be_b = be; addr_b = ad; din_b = d;
    endtask

    task automatic idle();
        set_a(0, 0, 2'b00, 4'd0, 16'h0);
        set_b(0, 0, 2'b00, 4'd0, 16'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (dout_a[u] !== 16'h0 || dout_b[u] !== 16'h0 || vld_a[u] !== 1'b0 ||
                vld_b[u] !== 1'b0 || coll[u] !== 1'b0 || aerr[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs u%0d: got a=%h b=%h va=%b vb=%b c=%b e=%b, want all 0",
                         u, dout_a[u], dout_b[u], vld_a[u], vld_b[u], coll[u], aerr[u]);
            end
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_read();
        for (int i = 0; i < 16; i++) begin
            set_a(1, 1, 2'b11, 4'(i), 16'h1000 + 16'(i));
            set_b(0, 0, 2'b00, 4'd0, 16'h0);
            exp_mem[i] = 16'h1000 + 16'(i);
            tick();
        end
        checks++;
        if (vld_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL fill_idle_b_valid: got %b want 0", vld_b[0]);
        end
        for (int i = 0; i < 16; i++) begin
            set_a(0, 0, 2'b00, 4'd0, 16'h0);
            set_b(1, 0, 2'b00, 4'(i), 16'h0);
            tick();
            checks++;
            if (dout_b[0] !== 16'h1000 + 16'(i) || vld_b[0] !== 1'b1 || coll[0] !== 1'b0) begin
                errors++;
                $display("FAIL fill_read addr %0d: got %h v=%b c=%b want %h v=1 c=0",
                         i, dout_b[0], vld_b[0], coll[0], 16'h1000 + 16'(i));
            end
            if (i >= 12) begin
                checks++;
                if (dout_b[3] !== 16'h0 || aerr[3] !== 1'b1 || vld_b[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_read_oor u3 addr %0d: got %h e=%b v=%b want 0000 e=1 v=1",
                             i, dout_b[3], aerr[3], vld_b[3]);
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_byte_enable();
        set_a(1, 1, 2'b11, 4'd3, 16'hAAAA); tick();
        set_a(1, 1, 2'b01, 4'd3, 16'h5555); tick();
        checks++;
        if (dout_a[0] !== 16'hAAAA) begin
            errors++;
            $display("FAIL be_read_first: got %h want aaaa", dout_a[0]);
        end
        checks++;
        if (dout_a[1] !== 16'hAA55) begin
            errors++;
            $display("FAIL be_write_first: got %h want aa55", dout_a[1]);
        end
        set_a(1, 0, 2'b00, 4'd3, 16'h0); tick();
        exp_mem[3] = 16'hAA55;
        checks++;
        if (dout_a[0] !== 16'hAA55) begin
            errors++;
            $display("FAIL be_merge: got %h want aa55", dout_a[0]);
        end
        idle();
        tick();
        checks++;
        if (vld_a[0] !== 1'b0 || dout_a[0] !== 16'hAA55) begin
            errors++;
            $display("FAIL idle_hold: got %h v=%b want aa55 v=0", dout_a[0], vld_a[0]);
        end
    endtask

    task automatic test_rdw();
        set_a(1, 1, 2'b11, 4'd5, 16'h1111); tick();
        set_a(1, 1, 2'b11, 4'd5, 16'h2222);
        set_b(1, 0, 2'b00, 4'd5, 16'h0);
        tick();
        exp_mem[5] = 16'h2222;
        checks++;
        if (dout_a[0] !== 16'h1111) begin
            errors++;
            $display("FAIL rdw_mode0_a: got %h want 1111", dout_a[0]);
        end
        checks++;
        if (dout_a[1] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_mode1_a: got %h want 2222", dout_a[1]);
        end
        checks++;
        if (dout_b[0] !== 16'h1111 || dout_b[1] !== 16'h1111) begin
            errors++;
            $display("FAIL rdw_cross_b: got %h/%h want 1111/1111", dout_b[0], dout_b[1]);
        end
        checks++;
        if (coll[0] !== 1'b0) begin
            errors++;
            $display("FAIL rdw_no_collision: got %b want 0", coll[0]);
        end
        set_a(0, 0, 2'b00, 4'd0, 16'h0);
        tick();
        checks++;
        if (dout_b[0] !== 16'h2222 || dout_b[1] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_next_b: got %h/%h want 2222/2222", dout_b[0], dout_b[1]);
        end
        idle();
        tick();
    endtask

    task automatic test_collision();
        set_a(1, 1, 2'b10, 4'd7, 16'hABCD);
        set_b(1, 1, 2'b11, 4'd7, 16'h1234);
        tick();
        exp_mem[7] = 16'hAB34;
        checks++;
        if (coll[0] !== 1'b1 || coll[2] !== 1'b0) begin
            errors++;
            $display("FAIL coll_pulse: got u0=%b u2=%b want 1/0", coll[0], coll[2]);
        end
        idle();
        tick();
        checks++;
        if (coll[0] !== 1'b0 || coll[2] !== 1'b1) begin
            errors++;
            $display("FAIL coll_one_cycle: got u0=%b u2=%b want 0/1", coll[0], coll[2]);
        end
        set_a(1, 0, 2'b00, 4'd7, 16'h0);
        tick();
        checks++;
        if (dout_a[0] !== 16'hAB34 || coll[2] !== 1'b0) begin
            errors++;
            $display("FAIL coll_merge: got %h c2=%b want ab34 c2=0", dout_a[0], coll[2]);
        end
        idle();
        tick();
    endtask

    task automatic test_latency_reset();
        set_a(1, 1, 2'b11, 4'd2, 16'h00F0); tick();
        exp_mem[2] = 16'h00F0;
        idle(); tick(); tick();
        set_a(1, 0, 2'b00, 4'd2, 16'h0);
        tick();
        idle();
        checks++;
        if (vld_a[2] !== 1'b0 || vld_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL lat_stage1: got u2 v=%b u0 v=%b want 0/1", vld_a[2], vld_a[0]);
        end
        tick();
        checks++;
        if (vld_a[2] !== 1'b1 || dout_a[2] !== 16'h00F0) begin
            errors++;
            $display("FAIL lat_stage2: got %h v=%b want 00f0 v=1", dout_a[2], vld_a[2]);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (dout_a[2] !== 16'h0 || vld_a[2] !== 1'b0 || dout_a[0] !== 16'h0 || dout_b[0] !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got u2=%h v=%b u0a=%h u0b=%h want 0",
                     dout_a[2], vld_a[2], dout_a[0], dout_b[0]);
        end
        // A write presented while reset is held must not land.
        set_a(1, 1, 2'b11, 4'd2, 16'hDEAD);
        tick();
        idle();
        #3 rst_n = 1'b1;
        tick();
        set_a(1, 0, 2'b00, 4'd2, 16'h0);
        tick(); idle(); tick();
        checks++;
        if (dout_a[2] !== 16'h00F0 || vld_a[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_keeps_mem: got %h v=%b want 00f0 v=1", dout_a[2], vld_a[2]);
        end
    endtask

    task automatic test_range();
        set_a(1, 1, 2'b11, 4'd13, 16'hBEEF);
        tick();
        checks++;
        if (aerr[3] !== 1'b1 || vld_a[3] !== 1'b1 || dout_a[3] !== 16'h0 || aerr[0] !== 1'b0) begin
            errors++;
            $display("FAIL range_write: got e3=%b v=%b d=%h e0=%b want 1/1/0000/0",
                     aerr[3], vld_a[3], dout_a[3], aerr[0]);
        end
        idle();
        tick();
        checks++;
        if (aerr[3] !== 1'b0) begin
            errors++;
            $display("FAIL range_pulse_end: got %b want 0", aerr[3]);
        end
        set_a(1, 0, 2'b00, 4'd12, 16'h0);
        set_b(1, 0, 2'b00, 4'd14, 16'h0);
        tick();
        idle();
        checks++;
        if (aerr[3] !== 1'b1 || dout_a[3] !== 16'h0 || dout_b[3] !== 16'h0) begin
            errors++;
            $display("FAIL range_both: got e=%b a=%h b=%h want 1/0/0", aerr[3], dout_a[3], dout_b[3]);
        end
        tick();
        checks++;
        if (aerr[3] !== 1'b0) begin
            errors++;
            $display("FAIL range_single_pulse: got %b want 0", aerr[3]);
        end
        for (int i = 0; i < 12; i++) begin
            set_b(1, 0, 2'b00, 4'(i), 16'h0);
            tick();
            checks++;
            if (dout_b[3] !== exp_mem[i] || aerr[3] !== 1'b0) begin
                errors++;
                $display("FAIL range_intact addr %0d: got %h e=%b want %h e=0",
                         i, dout_b[3], aerr[3], exp_mem[i]);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_latency_reset();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
